// File: rtl/pdm_cic_pkg.sv
// Shared constants and elaboration helpers for the PDM CIC decimator.
// Width helpers are evaluated at elaboration only; channel codes match data_out_ch.
package pdm_cic_pkg;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    function automatic int clog2(input int v);
        int r = 0;
        int x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Register width needed to hold the full (R*M)^N growth plus sign.
    function automatic int acc_w_needed(input int stages, input int max_dec, input int diff_dly);
        return stages * clog2((max_dec + 1) * diff_dly) + 1;
    endfunction

endpackage

// File: rtl/pdm_cic_decim_if.sv
// PCM output bus of the PDM decimator: data, channel tag, valid/ready.
// Producer holds data and valid stable until the consumer asserts ready.
interface pdm_cic_decim_if #(
    parameter int OUT_W = 24
);
    logic [OUT_W-1:0] data_out;
    logic             data_out_ch;
    logic             data_out_valid;
    logic             data_out_ready;

    modport master (output data_out, data_out_ch, data_out_valid, input data_out_ready);
    modport slave  (input data_out, data_out_ch, data_out_valid, output data_out_ready);
endinterface

// File: rtl/cic_channel.sv
// One CIC channel: registered integrator cascade on strobe, comb chain evaluated on dump.
// Latency: result is combinational during the dump cycle; no backpressure (caller owns buffering).
module cic_channel
    import pdm_cic_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int DIFF_DLY = 1,
    parameter int ACC_W    = 32
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    strobe,
    input  logic                    sample,
    input  logic                    dump,
    output logic signed [ACC_W-1:0] result,
    output logic                    done
);

    logic signed [ACC_W-1:0] integ [STAGES];
    logic signed [ACC_W-1:0] hist  [STAGES][DIFF_DLY];
    logic signed [ACC_W-1:0] diff  [STAGES+1];
    logic signed [ACC_W-1:0] x;

    assign x = sample ? ACC_W'(1) : '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                integ[k] <= '0;
                for (int d = 0; d < DIFF_DLY; d++) hist[k][d] <= '0;
            end
        end else begin
            // Each stage adds the previous stage's old value: one stage of ripple per strobe.
            if (strobe) begin
                integ[0] <= integ[0] + x;
                for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
            end
            if (dump) begin
                for (int k = 0; k < STAGES; k++) begin
                    hist[k][0] <= diff[k];
                    for (int d = 1; d < DIFF_DLY; d++) hist[k][d] <= hist[k][d-1];
                end
            end
        end
    end

    always_comb begin
        diff[0] = integ[STAGES-1];
        for (int k = 0; k < STAGES; k++) diff[k+1] = diff[k] - hist[k][DIFF_DLY-1];
    end

    assign result = diff[STAGES];
    assign done   = dump;

endmodule

// File: rtl/pdm_cic_decim.sv
// PDM mic clock generator + CIC decimator; PDM_CIC_STEREO_EN adds a left channel on rising mic_clk.
// Latency: data_out_valid rises 2 clk cycles after the strobe completing the R-th sample.
// Backpressure: single output register; a result arriving while valid&&!ready is dropped and sets overrun.
module pdm_cic_decim
    import pdm_cic_pkg::*;
#(
    parameter  int STAGES   = 3,
    parameter  int DIFF_DLY = 1,
    parameter  int ACC_W    = 32,
    parameter  int MAX_DEC  = 255,
    parameter  int OUT_W    = 24,
    localparam int DEC_W    = clog2(MAX_DEC + 1)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      clk_div,
    input  logic [DEC_W-1:0] dec_num,
    input  logic [4:0]       out_shift,
    output logic             mic_clk,
    input  logic             data_in,
    output logic             overrun,
    input  logic             ovr_clr,
    pdm_cic_decim_if.master  pcm
);

    if (acc_w_needed(STAGES, MAX_DEC, DIFF_DLY) > ACC_W || STAGES < 1 || STAGES > 6
        || DIFF_DLY < 1 || DIFF_DLY > 2) begin : g_param_err
        $error("pdm_cic_decim: illegal STAGES/DIFF_DLY or ACC_W too narrow for (MAX_DEC+1)*DIFF_DLY growth");
    end

    logic                    clr;
    logic [31:0]             div_cnt;
    logic                    tc;
    logic                    str_r;
    logic [DEC_W-1:0]        dec_cnt;
    logic [DEC_W-1:0]        dec_q;
    logic                    dec_last;
    logic                    dump_r;
    logic signed [ACC_W-1:0] res_r;
    logic                    done_r;
    logic                    res_vld;
    logic signed [ACC_W-1:0] res_dat;
    logic                    accept;
    logic                    drop;

    assign clr      = rst || !en;
    assign tc       = (div_cnt == 32'd0);
    assign str_r    = !clr && tc && mic_clk;
    assign dec_last = (dec_cnt == dec_q);

    // Down-counter reloads clk_div only at terminal count, so divider changes land on a clean edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt <= clk_div;
            mic_clk <= 1'b1;
        end else if (tc) begin
            div_cnt <= clk_div;
            mic_clk <= ~mic_clk;
        end else begin
            div_cnt <= div_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            dec_cnt <= '0;
            dec_q   <= dec_num;
            dump_r  <= 1'b0;
        end else begin
            dump_r <= str_r && dec_last;
            if (str_r) begin
                if (dec_last) begin
                    dec_cnt <= '0;
                    dec_q   <= dec_num;
                end else begin
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end
        end
    end

    cic_channel #(.STAGES(STAGES), .DIFF_DLY(DIFF_DLY), .ACC_W(ACC_W)) u_right (
        .clk(clk), .rst(clr), .strobe(str_r), .sample(data_in), .dump(dump_r),
        .result(res_r), .done(done_r)
    );

`ifdef PDM_CIC_STEREO_EN
    logic                    str_l;
    logic                    dump_l;
    logic signed [ACC_W-1:0] res_l;
    logic                    done_l;
    logic                    res_ch;

    assign str_l = !clr && tc && !mic_clk;

    // Left dumps on the rising-edge sample that precedes the right wrap, so left leads each period.
    always_ff @(posedge clk) begin
        if (clr) dump_l <= 1'b0;
        else     dump_l <= str_l && dec_last;
    end

    cic_channel #(.STAGES(STAGES), .DIFF_DLY(DIFF_DLY), .ACC_W(ACC_W)) u_left (
        .clk(clk), .rst(clr), .strobe(str_l), .sample(data_in), .dump(dump_l),
        .result(res_l), .done(done_l)
    );

    assign res_vld = done_l || done_r;
    assign res_dat = done_l ? res_l : res_r;
    assign res_ch  = done_l ? CH_LEFT : CH_RIGHT;

    always_ff @(posedge clk) begin
        if (clr)                                          pcm.data_out_ch <= 1'b0;
        else if (res_vld && (!pcm.data_out_valid || accept)) pcm.data_out_ch <= res_ch;
    end
`else
    assign res_vld         = done_r;
    assign res_dat         = res_r;
    assign pcm.data_out_ch = CH_RIGHT;
`endif

    assign accept = pcm.data_out_valid && pcm.data_out_ready;
    assign drop   = res_vld && pcm.data_out_valid && !pcm.data_out_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            pcm.data_out       <= '0;
            pcm.data_out_valid <= 1'b0;
            overrun            <= 1'b0;
        end else begin
            if (res_vld && (!pcm.data_out_valid || accept)) begin
                pcm.data_out       <= OUT_W'(res_dat >>> out_shift);
                pcm.data_out_valid <= 1'b1;
            end else if (accept) begin
                pcm.data_out_valid <= 1'b0;
            end
            if (drop)         overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Directed bench for pdm_cic_decim: constant, alternating and stereo PDM patterns with hand-computed PCM.
// Gain is 64^3 = 262144 for R=64, M=1, N=3; settled results start after three startup results per channel.
module tb_pdm_cic_decim;

`ifdef PDM_CIC_STEREO_EN
    localparam int NCH = 2;
`else
    localparam int NCH = 1;
`endif
    localparam int GAIN = 262144;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [31:0] clk_div = 32'd24;
    logic [7:0]  dec_num = 8'd63;
    logic [4:0]  out_shift = 5'd0;
    logic        mic_clk;
    logic        data_in;
    logic        overrun;
    logic        ovr_clr = 1'b0;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   mode = 0;
    logic data_bit = 1'b1;
    logic alt = 1'b0;
    int   q_dat[$];
    int   q_ch[$];

    pdm_cic_decim_if #(.OUT_W(24)) pcm ();

    pdm_cic_decim dut (
        .clk(clk), .rst(rst), .en(en), .clk_div(clk_div), .dec_num(dec_num),
        .out_shift(out_shift), .mic_clk(mic_clk), .data_in(data_in),
        .overrun(overrun), .ovr_clr(ovr_clr), .pcm(pcm)
    );

    always #10 clk = ~clk;

    // Microphone model: constant bit, bit toggling per falling mic_clk, or left=1/right=0.
    always @(negedge mic_clk) alt = ~alt;

    always_comb begin
        case (mode)
            0:       data_in = data_bit;
            1:       data_in = alt;
            default: data_in = ~mic_clk;
        endcase
    end

    always @(negedge clk) begin
        #1;
        if (pcm.data_out_valid && pcm.data_out_ready) begin
            q_dat.push_back(int'($signed(pcm.data_out)));
            q_ch.push_back(int'(pcm.data_out_ch));
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic int qd(input int i);
        return (i < q_dat.size()) ? q_dat[i] : 32'h7fff_ffff;
    endfunction

    function automatic int qc(input int i);
        return (i < q_ch.size()) ? q_ch[i] : -1;
    endfunction

    task automatic do_reset(input int div);
        clk_div = div;
        rst = 1'b1;
        en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q_dat.delete();
        q_ch.delete();
    endtask

    task automatic wait_n(input string tag, input int n, input int budget);
        int c = 0;
        while (q_dat.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, int'(q_dat.size() >= n), 1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int c = 0;
        while (!pcm.data_out_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, int'(pcm.data_out_valid), 1);
    endtask

    initial begin
        int n;
        int since;
        logic mic_prev;

        pcm.data_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mic_clk", int'(mic_clk), 1);
        chk("rst_valid", int'(pcm.data_out_valid), 0);
        chk("rst_data", int'(pcm.data_out), 0);
        chk("rst_overrun", int'(overrun), 0);

        // en low holds everything in reset even with rst released
        rst = 1'b0;
        en = 1'b0;
        repeat (60) @(negedge clk);
        chk("en0_mic_clk", int'(mic_clk), 1);
        chk("en0_valid", int'(pcm.data_out_valid), 0);

        // Scenario 1: constant 1 at clk_div=24
        en = 1'b1;
        n = 0;
        while (mic_clk && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!mic_clk && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("half_period", n, 25);

        since = 0;
        n = 0;
        mic_prev = mic_clk;
        while (!pcm.data_out_valid && n < 5000) begin
            @(negedge clk);
            n++;
            if (mic_prev && !mic_clk) since = 0;
            else                      since++;
            mic_prev = mic_clk;
        end
        chk("latency_after_strobe", since + 1, 2);

        wait_n("s1_results", 3 * NCH + 2, 20000 * NCH);
        chk("s1_settled_a", qd(3 * NCH), GAIN);
        chk("s1_settled_b", qd(3 * NCH + 1), GAIN);
`ifndef PDM_CIC_STEREO_EN
        chk("s1_ch", qc(3), 1);
`endif

        // Scenario 2: constant 0, then out_shift=4
        mode = 0;
        data_bit = 1'b0;
        do_reset(3);
        wait_n("s2_results", 3 * NCH + 2, 3000 * NCH);
        chk("s2_settled_a", qd(3 * NCH), -GAIN);
        chk("s2_settled_b", qd(3 * NCH + 1), -GAIN);
        out_shift = 5'd4;
        wait_n("s2_shift_result", 4 * NCH + 2, 1500 * NCH);
        chk("s2_shift4", qd(4 * NCH + 1), -16384);
        out_shift = 5'd0;

        // Scenario 3: alternating samples cancel for even R
        mode = 1;
        do_reset(3);
        wait_n("s3_results", 3 * NCH + 2, 3000 * NCH);
        chk("s3_alt_a", qd(3 * NCH), 0);
        chk("s3_alt_b", qd(3 * NCH + 1), 0);

        // Scenario 4: backpressure, overrun and clear
        mode = 0;
        data_bit = 1'b1;
        do_reset(3);
        wait_n("s4_warmup", 4 * NCH, 3000 * NCH);
        pcm.data_out_ready = 1'b0;
        wait_valid("s4_valid", 1500);
        chk("s4_held_first", int'($signed(pcm.data_out)), GAIN);
        chk("s4_no_overrun_yet", int'(overrun), 0);
        data_bit = 1'b0;
        n = 0;
        while (!overrun && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk("s4_overrun", int'(overrun), 1);
        chk("s4_data_unchanged", int'($signed(pcm.data_out)), GAIN);
        chk("s4_valid_held", int'(pcm.data_out_valid), 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("s4_ovr_clr", int'(overrun), 0);
        pcm.data_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("s4_valid_after_accept", int'(pcm.data_out_valid), 0);
        chk("s4_accepted_data", qd(q_dat.size() - 1), GAIN);

        // Scenario 6: reset mid-frame while a result is held
        mode = 0;
        data_bit = 1'b1;
        pcm.data_out_ready = 1'b0;
        do_reset(3);
        wait_valid("s6_valid", 1500);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_valid_cleared", int'(pcm.data_out_valid), 0);
        chk("s6_mic_clk_high", int'(mic_clk), 1);
        chk("s6_data_cleared", int'(pcm.data_out), 0);
        rst = 1'b0;
        pcm.data_out_ready = 1'b1;
        q_dat.delete();
        q_ch.delete();
        wait_n("s6_results", 3 * NCH + 2, 3000 * NCH);
        chk("s6_settled_a", qd(3 * NCH), GAIN);
        chk("s6_settled_b", qd(3 * NCH + 1), GAIN);

`ifdef PDM_CIC_STEREO_EN
        // Scenario 5: left=1, right=0; results alternate left first
        mode = 2;
        do_reset(3);
        wait_n("s5_results", 10, 6000);
        for (int i = 6; i < 10; i++) begin
            chk("s5_ch", qc(i), i % 2);
            chk("s5_data", qd(i), (i % 2 == 1) ? -GAIN : GAIN);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
